// File: rtl/p6_alu_arbiter.sv
// Two-port round-robin arbiter that time-shares one external 16-bit ALU.
// Each requester gets a valid/ready op channel and a valid/ready response channel.
module p6_alu_arbiter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_n,
    output logic             rsp_v,
    output logic             rsp_z,
    output logic [WIDTH-1:0] alu_ain,
    output logic [WIDTH-1:0] alu_bin,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_n,
    input  logic             alu_v,
    input  logic             alu_z,
    output logic [2:0]       status_nvz,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             prio_q;
    logic             owner_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       flags_q;
    logic [2:0]       status_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;
    logic             busy_q;

    logic gnt_any;
    logic gnt_sel;
    logic rsp_fire;

    // Grant decision in IDLE: a lone valid wins, a tie goes to prio.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_sel  = 1'b0;
        rsp_fire = 1'b0;
        if (state_q == IDLE) begin
            gnt_any = req0_valid | req1_valid;
            gnt_sel = (req0_valid && req1_valid) ? prio_q : req1_valid;
        end
        if (state_q == RESP) begin
            rsp_fire = owner_q ? rsp1_ready : rsp0_ready;
        end
    end

    always_comb begin
        req0_ready = gnt_any & ~gnt_sel;
        req1_ready = gnt_any &  gnt_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 2'b00;
            data_q       <= '0;
            flags_q      <= 3'b000;
            status_q     <= 3'b000;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        owner_q <= gnt_sel;
                        a_q     <= gnt_sel ? req1_a  : req0_a;
                        b_q     <= gnt_sel ? req1_b  : req0_b;
                        op_q    <= gnt_sel ? req1_op : req0_op;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // Capture ALU outputs; hand the next tie to the other requester.
                    data_q       <= alu_out;
                    flags_q      <= {alu_n, alu_v, alu_z};
                    status_q     <= {alu_n, alu_v, alu_z};
                    prio_q       <= ~owner_q;
                    rsp0_valid_q <= ~owner_q;
                    rsp1_valid_q <= owner_q;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_fire) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_ain    = a_q;
    assign alu_bin    = b_q;
    assign alu_op     = op_q;
    assign rsp_data   = data_q;
    assign rsp_n      = flags_q[2];
    assign rsp_v      = flags_q[1];
    assign rsp_z      = flags_q[0];
    assign status_nvz = status_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign busy       = busy_q;

endmodule

// File: doc/p6_alu_arbiter.md
# p6_alu_arbiter

Two-port round-robin arbiter and sequencer that shares the single 16-bit ALU (add, sub, and, not; N/V/Z flags) between two requesters, for example the datapath controller and a branch/compare unit. Each requester submits an operation on a valid/ready channel and receives its result and flags on its own valid/ready response channel. The block drives the ALU operand and op inputs from registered values and captures its combinational outputs. It also keeps a sticky status register of the last N/V/Z for branch evaluation.

## Interface
- WIDTH, 16, operand/result width; ALU flags use bit WIDTH-1 as sign
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid / req1_valid  input  1  requester k presents an operation
- req0_ready / req1_ready  output  1  operation accepted this cycle (valid && ready)
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands A and B
- req0_op / req1_op  input  2  ALU op: 00 add, 01 sub, 10 and, 11 not B
- rsp0_valid / rsp1_valid  output  1  result available for requester k
- rsp0_ready / rsp1_ready  input  1  requester k takes the result
- rsp_data  output  WIDTH  result, shared by both response ports; meaningful only with a rspk_valid
- rsp_n, rsp_v, rsp_z  output  1  flags captured with rsp_data
- alu_ain, alu_bin  output  WIDTH  operands to the ALU
- alu_op  output  2  op to the ALU
- alu_out  input  WIDTH  ALU result (combinational from alu_*)
- alu_n, alu_v, alu_z  input  1  ALU flags
- status_nvz  output  3  {N,V,Z} of the last completed operation
- busy  output  1  high when the FSM is not in IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If neither valid is high, stay in IDLE.
  - If exactly one valid is high, grant it.
  - If both are high, grant the requester named by the 1-bit priority pointer `prio`.
  - Grant k: reqk_ready=1 in the same cycle (combinational). Latch a, b, op into operand registers and latch owner=k. Go to EXEC.
- EXEC: alu_ain/alu_bin/alu_op reflect the latched operands for the whole cycle. At the clock edge:
  - capture alu_out→rsp_data and alu_n/v/z→rsp_n/v/z;
  - load status_nvz;
  - set prio = ~owner;
  - go to RESP.
- RESP:
  - rsp{owner}_valid=1; the other rsp valid stays 0.
  - rsp_data and flags are held stable.
  - When rsp{owner}_ready=1, the transfer completes and the FSM returns to IDLE.
  - The ready of the non-owner port is ignored.
- Both req_ready outputs are 0 in EXEC and RESP. There is no request queuing.
- alu_* outputs hold the last latched operands in every state.
- The block performs no arithmetic itself. Width and flag semantics come entirely from the ALU; results are passed through unmodified.
- Requesters must not make valid depend on ready. ready may depend combinationally on valid.

## Timing
- Reset (async assert, sync deassertion by the system) sets:
  - FSM to IDLE and prio=0 (req0 preferred);
  - owner=0 and operand registers to 0, so alu_ain=alu_bin=0 and alu_op=00;
  - rsp_data=0, rsp_n/v/z=0, status_nvz=000;
  - both rsp valids=0, both req readys=0 (no valid in reset), busy=0.
- Reset mid-operation (EXEC or RESP):
  - the operation is dropped and no response is produced;
  - status_nvz returns to 000.
- Latency: accept at edge T → rspk_valid high from T+2. Capture occurs at the end of the EXEC cycle, T+1.
- Minimum issue interval is 3 cycles when rsp_ready is already high in RESP.
- Back-pressure:
  - rsp_ready low holds RESP indefinitely with outputs stable;
  - no new request is accepted until the response transfers.
- A valid that arrives while busy waits. Its operands must stay stable until accepted.
- Fairness: after serving k, the other requester wins the next tie, so both continuously valid alternate 0,1,0,1.
- status_nvz changes only at the EXEC→RESP edge.

## Test plan
- req0 add 0x7FFF+0x0001 accepted at T → rsp0_valid at T+2, rsp_data=0x8000, N=1 V=1 Z=0, status_nvz=110; rsp1_valid stays 0.
- req1 sub 0x0005-0x0005 alone → rsp1_valid at T+2 with rsp_data=0x0000, Z=1, N=0, V=0; alu_op observed 01 during EXEC.
- req0 and req1 both valid continuously from reset, each response readied immediately → grants alternate 0,1,0,1, one accept every 3 cycles; after req1 alone is served, a tie goes to req0.
- req0 and 0xF0F0&0x0FF0, then hold rsp0_ready low 5 cycles → rsp0_valid and rsp_data=0x00F0 stable for 6 cycles; req1_valid high throughout is not accepted until the cycle after the transfer.
- Assert rst_n low during EXEC of a not-0x00FF operation → no rsp valid; all outputs at reset values immediately; after release, the first tie grants req0.
- req1 not-0x0000 → rsp_data=0xFFFF, N=1, V=0, Z=0; busy high for exactly the EXEC and RESP cycles.
